// File: rtl/mem_apb_arbiter_pkg.sv
// Shared types for the APB memory arbiter: bus phase states, transfer owner,
// and a width helper for the starvation run counter.
package mem_apb_arbiter_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LSU   = 1'b1
  } mem_owner_e;

  // Counter must be able to hold MAX_LSU_RUN itself.
  function automatic int unsigned run_cnt_w(input int unsigned max_run);
    return (max_run < 2) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/mem_req_arb.sv
// Fetch/LSU request picker. LSU has priority; after MAX_LSU_RUN LSU grants
// taken while fetch was waiting, a pending fetch is forced through.
module mem_req_arb
  import mem_apb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LSU_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en_i,
  input  logic if_req_i,
  input  logic lsu_req_i,
  output logic if_gnt_o,
  output logic lsu_gnt_o,
  output logic owner_o
);

  localparam int unsigned CNT_W = run_cnt_w(MAX_LSU_RUN);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_LSU_RUN);

  logic [CNT_W-1:0] run_q, run_d;
  logic             force_fetch;
  logic             lsu_pick;
  logic             if_pick;

  always_comb begin
    force_fetch = if_req_i && (run_q == RUN_MAX);
    lsu_pick    = lsu_req_i && !force_fetch;
    if_pick     = if_req_i && !lsu_pick;
    lsu_gnt_o   = grant_en_i && lsu_pick;
    if_gnt_o    = grant_en_i && if_pick;
    owner_o     = lsu_pick ? OWN_LSU : OWN_FETCH;
  end

  // Run only counts LSU grants that actually made fetch wait.
  always_comb begin
    run_d = run_q;
    if (!if_req_i || if_gnt_o) begin
      run_d = '0;
    end else if (lsu_gnt_o && (run_q != RUN_MAX)) begin
      run_d = run_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/mem_apb_arbiter.sv
// Shares one APB master between fetch (reads) and LSU (loads/stores):
// arbitration at each grant point, SETUP/ACCESS sequencing, response routing.
module mem_apb_arbiter
  import mem_apb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_LSU_RUN = 4,
  localparam int unsigned STRB_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic [STRB_W-1:0] lsu_strb_i,
  output logic              lsu_gnt_o,
  output logic              lsu_done_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic [STRB_W-1:0] pstrb_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  apb_state_e        state_q, state_d;
  logic              any_req;
  logic              grant_en;
  logic              xfer_end;
  logic              arb_owner;
  logic              if_gnt;
  logic              lsu_gnt;

  logic              owner_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic              if_done_q, lsu_done_q;
  logic [DATA_W-1:0] if_rdata_q, lsu_rdata_q;
  logic              if_err_q, lsu_err_q;

  assign any_req  = if_req_i || lsu_req_i;
  assign xfer_end = (state_q == APB_ACCESS) && pready_i;
  // Grants are held off while reset is asserted so every output reads 0.
  assign grant_en = !rst && ((state_q == APB_IDLE) || xfer_end);

  mem_req_arb #(
    .MAX_LSU_RUN (MAX_LSU_RUN)
  ) u_req_arb (
    .clk        (clk),
    .rst        (rst),
    .grant_en_i (grant_en),
    .if_req_i   (if_req_i),
    .lsu_req_i  (lsu_req_i),
    .if_gnt_o   (if_gnt),
    .lsu_gnt_o  (lsu_gnt),
    .owner_o    (arb_owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= APB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE:   if (any_req) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (pready_i) state_d = any_req ? APB_SETUP : APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  always_comb begin
    psel_o    = (state_q == APB_SETUP) || (state_q == APB_ACCESS);
    penable_o = (state_q == APB_ACCESS);
    if_gnt_o  = if_gnt;
    lsu_gnt_o = lsu_gnt;
  end

  // Fields are captured only at a grant, so they hold through the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_FETCH;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (if_gnt || lsu_gnt) begin
      owner_q  <= arb_owner;
      pwrite_q <= lsu_gnt && lsu_we_i;
      paddr_q  <= lsu_gnt ? lsu_addr_i : if_addr_i;
      pwdata_q <= lsu_gnt ? lsu_wdata_i : '0;
      pstrb_q  <= lsu_gnt ? lsu_strb_i : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_done_q   <= 1'b0;
      lsu_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
      if_err_q    <= 1'b0;
      lsu_err_q   <= 1'b0;
    end else begin
      if_done_q  <= xfer_end && (owner_q == OWN_FETCH);
      lsu_done_q <= xfer_end && (owner_q == OWN_LSU);
      if (xfer_end) begin
        if (owner_q == OWN_FETCH) begin
          if_rdata_q <= prdata_i;
          if_err_q   <= pslverr_i;
        end else begin
          lsu_rdata_q <= pwrite_q ? '0 : prdata_i;
          lsu_err_q   <= pslverr_i;
        end
      end
    end
  end

  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign if_done_o   = if_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign lsu_done_o  = lsu_done_q;
  assign lsu_rdata_o = lsu_rdata_q;
  assign lsu_err_o   = lsu_err_q;

endmodule

// File: tb/tb_mem_apb_arbiter.sv
// Directed bench for mem_apb_arbiter: single transfers, wait states, starvation
// order, slave error, reset in ACCESS and requests raised during SETUP.
module tb_mem_apb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_done_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [3:0]  lsu_strb_i;
  logic        lsu_gnt_o, lsu_done_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i, pslverr_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LSU_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_done_o(if_done_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_strb_i(lsu_strb_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int  ng;
    logic seen;
    rst = 1'b1;
    if_req_i = 0; if_addr_i = 0;
    lsu_req_i = 0; lsu_we_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; lsu_strb_i = 0;
    prdata_i = 0; pready_i = 0; pslverr_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_dones", {if_done_o, lsu_done_o}, 0);
    chk("rst_gnts", {if_gnt_o, lsu_gnt_o}, 0);
    cyc();
    rst = 1'b0;

    // Lone fetch, zero wait states
    cyc();
    if_req_i = 1; if_addr_i = 32'h100; pready_i = 1; prdata_i = 32'hCAFE0100;
    @(negedge clk);
    chk("f_gnt", {if_gnt_o, lsu_gnt_o}, 2'b10);
    chk("f_idle_psel", psel_o, 0);
    cyc(); if_req_i = 0;
    @(negedge clk);
    chk("f_setup", {psel_o, penable_o, pwrite_o}, 3'b100);
    chk("f_paddr", paddr_o, 32'h100);
    chk("f_pstrb", pstrb_o, 0);
    cyc();
    @(negedge clk);
    chk("f_access", {psel_o, penable_o}, 2'b11);
    cyc();
    @(negedge clk);
    chk("f_done", {if_done_o, lsu_done_o}, 2'b10);
    chk("f_rdata", if_rdata_o, 32'hCAFE0100);
    chk("f_idle_after", psel_o, 0);
    cyc();
    @(negedge clk);
    chk("f_done_pulse", if_done_o, 0);

    // Store with two wait states
    cyc();
    lsu_req_i = 1; lsu_we_i = 1; lsu_addr_i = 32'h2000; lsu_wdata_i = 32'hDEADBEEF;
    lsu_strb_i = 4'hF; pready_i = 0; prdata_i = 32'h55555555;
    @(negedge clk);
    chk("s_gnt", {if_gnt_o, lsu_gnt_o}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      cyc();
      lsu_req_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; lsu_strb_i = 0; lsu_we_i = 0;
      if (i == 3) pready_i = 1;
      @(negedge clk);
      chk("s_fields", {psel_o, pwrite_o, paddr_o, pstrb_o}, {1'b1, 1'b1, 32'h2000, 4'hF});
      chk("s_wdata", pwdata_o, 32'hDEADBEEF);
      chk("s_penable", penable_o, (i > 0));
      chk("s_no_done", lsu_done_o, 0);
    end
    cyc();
    @(negedge clk);
    chk("s_done", {if_done_o, lsu_done_o}, 2'b01);
    chk("s_rdata_zero", lsu_rdata_o, 0);
    cyc();
    @(negedge clk);
    chk("s_done_pulse", lsu_done_o, 0);

    // Both held continuously: starvation order, no idle gap
    cyc();
    if_req_i = 1; if_addr_i = 32'h140;
    lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h3100;
    ng = 0; seen = 0;
    for (int c = 0; c < 40 && ng < 10; c++) begin
      @(negedge clk);
      if (seen) chk("b2b_psel", psel_o, 1);
      if (if_gnt_o || lsu_gnt_o) begin
        chk("one_gnt", if_gnt_o && lsu_gnt_o, 0);
        chk("order", lsu_gnt_o, exp_order[ng]);
        ng++;
        seen = 1;
      end
      if (ng < 10) cyc();
    end
    chk("order_cnt", ng, 10);
    cyc();
    if_req_i = 0; lsu_req_i = 0;
    repeat (4) cyc();

    // Load with slave error, then a clean fetch
    lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h3000;
    pready_i = 1; pslverr_i = 1; prdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    chk("e_gnt", lsu_gnt_o, 1);
    cyc(); lsu_req_i = 0;
    cyc();
    cyc();
    @(negedge clk);
    chk("e_done", {lsu_done_o, lsu_err_o}, 2'b11);
    chk("e_rdata", lsu_rdata_o, 32'hBAD0BAD0);
    cyc();
    pslverr_i = 0; prdata_i = 32'h11112222; if_req_i = 1; if_addr_i = 32'h104;
    @(negedge clk);
    chk("e_f_gnt", if_gnt_o, 1);
    cyc(); if_req_i = 0;
    cyc();
    cyc();
    @(negedge clk);
    chk("e_f_done", {if_done_o, if_err_o}, 2'b10);
    chk("e_f_rdata", if_rdata_o, 32'h11112222);
    cyc();

    // Reset asserted while in ACCESS
    if_req_i = 1; if_addr_i = 32'h108; pready_i = 0;
    @(negedge clk);
    chk("r_gnt", if_gnt_o, 1);
    cyc(); if_req_i = 0;
    cyc();
    @(negedge clk);
    chk("r_access", {psel_o, penable_o}, 2'b11);
    lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h4000;
    #1;
    chk("r_wait_no_gnt", {if_gnt_o, lsu_gnt_o}, 0);
    #1; rst = 1;
    #1;
    chk("r_outs", {psel_o, penable_o, pwrite_o, if_gnt_o, lsu_gnt_o, if_done_o, lsu_done_o}, 0);
    chk("r_paddr", paddr_o, 0);
    @(posedge clk); #1;
    rst = 0; pready_i = 1;
    @(negedge clk);
    chk("r_idle_gnt", {psel_o, lsu_gnt_o, if_done_o}, 3'b010);
    cyc(); lsu_req_i = 0;
    @(negedge clk);
    chk("r_setup", {psel_o, penable_o, if_done_o}, 3'b100);
    chk("r_paddr2", paddr_o, 32'h4000);
    cyc();
    @(negedge clk);
    chk("r_acc2", {penable_o, if_done_o}, 2'b10);
    cyc();
    @(negedge clk);
    chk("r_done", {if_done_o, lsu_done_o}, 2'b01);
    cyc();

    // Requests raised during SETUP wait for ACCESS&&pready
    if_req_i = 1; if_addr_i = 32'h180; pready_i = 0;
    @(negedge clk);
    chk("q_gnt0", if_gnt_o, 1);
    cyc();
    if_addr_i = 32'h200; lsu_req_i = 1; lsu_addr_i = 32'h5000;
    @(negedge clk);
    chk("q_setup_nognt", {if_gnt_o, lsu_gnt_o}, 0);
    cyc();
    @(negedge clk);
    chk("q_wait_nognt", {if_gnt_o, lsu_gnt_o}, 0);
    cyc(); pready_i = 1;
    @(negedge clk);
    chk("q_lsu_first", {if_gnt_o, lsu_gnt_o}, 2'b01);
    cyc(); lsu_req_i = 0;
    @(negedge clk);
    chk("q_f_done", {if_done_o, lsu_done_o, if_gnt_o}, 3'b100);
    chk("q_paddr", paddr_o, 32'h5000);
    cyc();
    @(negedge clk);
    chk("q_f_gnt", {if_gnt_o, lsu_gnt_o}, 2'b10);
    cyc(); if_req_i = 0;
    @(negedge clk);
    chk("q_l_done", {if_done_o, lsu_done_o}, 2'b01);
    chk("q_paddr2", paddr_o, 32'h200);
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
